// File: rtl/serial_frame_receiver.sv
// Receive side of the TRNG serial link: synchronises the async data clock, data and
// sync lines, rebuilds MSB-first bytes and hands them to a first-word-fall-through FIFO.
module serial_frame_receiver #(
  parameter int unsigned FIFODepthLog = 3,
  parameter int unsigned TimeoutLog   = 8,
  parameter int unsigned ByteCntWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dataClkIn,
  input  logic                    dataIn,
  input  logic                    syncIn,
  output logic [7:0]              rx_byte,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    frameErr,
  output logic                    overflow,
  output logic                    aligned,
  output logic [ByteCntWidth-1:0] byteCnt
);

  localparam int unsigned Depth = 1 << FIFODepthLog;
  localparam int unsigned CntW  = FIFODepthLog + 1;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  // Input synchronisers; the clock chain has an extra stage for edge detection
  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic [1:0] sync_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      sync_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], dataClkIn};
      data_sync <= {data_sync[0], dataIn};
      sync_sync <= {sync_sync[0], syncIn};
    end
  end

  logic link_edge;
  logic data_bit;
  logic sync_bit;

  assign link_edge = clk_sync[1] & ~clk_sync[2];
  assign data_bit  = data_sync[1];
  assign sync_bit  = sync_sync[1];

  // Framing FSM state and datapath
  state_t                state;
  state_t                state_next;
  logic [2:0]            bit_cnt;
  logic [2:0]            bit_cnt_next;
  logic [7:0]            shreg;
  logic [7:0]            shreg_next;
  logic [TimeoutLog-1:0] idle_cnt;
  logic [TimeoutLog-1:0] idle_cnt_next;
  logic                  frame_err_next;
  logic                  done;
  logic                  done_next;
  logic [7:0]            done_byte;
  logic [7:0]            done_byte_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      frameErr  <= 1'b0;
      aligned   <= 1'b0;
      done      <= 1'b0;
      done_byte <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      idle_cnt  <= idle_cnt_next;
      frameErr  <= frame_err_next;
      aligned   <= (state_next == RECV);
      done      <= done_next;
      done_byte <= done_byte_next;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shreg_next     = shreg;
    idle_cnt_next  = '0;
    frame_err_next = 1'b0;
    done_next      = 1'b0;
    done_byte_next = done_byte;
    case (state)
      HUNT: begin
        if (link_edge && sync_bit) begin
          shreg_next   = {7'b0, data_bit};
          bit_cnt_next = 3'd1;
          state_next   = RECV;
        end
      end
      RECV: begin
        if (link_edge) begin
          if (sync_bit) begin
            // A sync mid-byte means the sender restarted; drop the partial byte
            frame_err_next = (bit_cnt != 3'd0);
            shreg_next     = {7'b0, data_bit};
            bit_cnt_next   = 3'd1;
          end else begin
            shreg_next   = {shreg[6:0], data_bit};
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              done_next      = 1'b1;
              done_byte_next = {shreg[6:0], data_bit};
            end
          end
        end else if (bit_cnt != 3'd0) begin
          if (idle_cnt == {TimeoutLog{1'b1}}) begin
            frame_err_next = 1'b1;
            bit_cnt_next   = 3'd0;
            state_next     = HUNT;
          end else begin
            idle_cnt_next = idle_cnt + TimeoutLog'(1);
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Output FIFO with registered head (first-word fall-through)
  logic [7:0]              mem [Depth];
  logic [FIFODepthLog-1:0] wr_ptr;
  logic [FIFODepthLog-1:0] rd_ptr;
  logic [FIFODepthLog-1:0] rd_ptr_next;
  logic [CntW-1:0]         count;
  logic [CntW-1:0]         count_next;
  logic [CntW-1:0]         count_after_rd;
  logic                    rd;
  logic                    wr_ok;
  logic                    drop;
  logic [7:0]              head_next;

  always_comb begin
    rd             = rx_valid & rx_ready;
    wr_ok          = done & ((count != CntW'(Depth)) | rd);
    drop           = done & ~wr_ok;
    rd_ptr_next    = rd ? rd_ptr + FIFODepthLog'(1) : rd_ptr;
    count_after_rd = count - CntW'(rd);
    count_next     = count_after_rd + CntW'(wr_ok);
    head_next      = rx_byte;
    // A write into an empty FIFO bypasses the memory straight to the head
    if (wr_ok && (count_after_rd == '0)) begin
      head_next = done_byte;
    end else if (count_next != '0) begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= done_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      overflow <= 1'b0;
      byteCnt  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + FIFODepthLog'(1);
      end
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rx_valid <= (count_next != '0);
      rx_byte  <= head_next;
      overflow <= overflow | drop;
      byteCnt  <= byteCnt + ByteCntWidth'(wr_ok);
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: drives the serial link, predicts delivered
// bytes, framing errors, overflow and byte count from link-level rules.
module tb_serial_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        dataClkIn;
  logic        dataIn;
  logic        syncIn;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        frameErr;
  logic        overflow;
  logic        aligned;
  logic [15:0] byteCnt;

  always #5 clk = ~clk;

  serial_frame_receiver #(
    .FIFODepthLog(3),
    .TimeoutLog  (8),
    .ByteCntWidth(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataClkIn(dataClkIn),
    .dataIn   (dataIn),
    .syncIn   (syncIn),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frameErr (frameErr),
    .overflow (overflow),
    .aligned  (aligned),
    .byteCnt  (byteCnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise = 0;

  // Link-level model: bytes expected at the consumer, in order
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  int         exp_cnt = 0;
  logic       exp_ovf = 1'b0;
  int         fe_seen = 0;

  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] prev_b = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Every cycle: delivered bytes match the model, head holds under back-pressure
  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 1'b0;
      prev_r  = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (frameErr) fe_seen++;
      if (frameErr && prev_fe) check("frameErr_pulse_width", 32'd2, 32'd1);
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(rx_valid), 32'd1);
        check("hold_byte", 32'(rx_byte), 32'(prev_b));
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(rx_byte), 32'hFFFF_FFFF);
        else check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
      end
      prev_v  = rx_valid;
      prev_r  = rx_ready;
      prev_fe = frameErr;
      prev_b  = rx_byte;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A byte that finishes cleanly is stored if the 8-deep FIFO has room
  task automatic model_byte(input logic [7:0] b);
    if (exp_q.size() < 8) begin
      exp_q.push_back(b);
      exp_cnt++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic send_bit(input logic d, input logic s);
    dataIn = d;
    syncIn = s;
    repeat (4) tick();
    dataClkIn = 1'b1;
    last_rise = cyc;
    repeat (8) tick();
    dataClkIn = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == 7);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0], i == 0);
  endtask

  task automatic settle(input string tag);
    int budget;
    budget = 300;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() != 0) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (10) tick();
    check({tag, "_frameErr_count"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, "_byteCnt"}, 32'(byteCnt), 32'(exp_cnt[15:0]));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_byte"}, 32'(rx_byte), 32'd0);
    check({tag, "_frameErr"}, 32'(frameErr), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_aligned"}, 32'(aligned), 32'd0);
    check({tag, "_byteCnt"}, 32'(byteCnt), 32'd0);
  endtask

  initial begin
    int first_al;
    int fe_cyc;
    int delta;
    logic [7:0] b81;
    rst       = 1'b1;
    dataClkIn = 1'b0;
    dataIn    = 1'b0;
    syncIn    = 1'b0;
    rx_ready  = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) tick();

    // Unsynced edges are ignored; alignment starts at the sync edge
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    check("t2_aligned_before_sync", 32'(aligned), 32'd0);
    b81 = 8'h81;
    model_byte(b81);
    dataIn = b81[7];
    syncIn = 1'b1;
    repeat (4) tick();
    dataClkIn = 1'b1;
    first_al = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (aligned && first_al < 0) first_al = i;
    end
    tests++;
    if (first_al < 2 || first_al > 5) begin
      fails++;
      $display("FAIL t2_aligned_rise: actual=%0d cycles after sync edge required=2..5", first_al);
    end
    dataClkIn = 1'b0;
    repeat (4) tick();
    for (int i = 6; i >= 0; i--) send_bit(b81[i], 1'b0);
    settle("t2");
    check("t2_byteCnt_lit", 32'(byteCnt), 32'd1);

    // Back-to-back bytes
    send_byte(8'hA5);
    send_byte(8'h3C);
    settle("t1");
    check("t1_byteCnt_lit", 32'(byteCnt), 32'd3);
    check("t1_aligned", 32'(aligned), 32'd1);

    // Sync arriving mid-byte
    send_partial(3);
    exp_fe++;
    send_byte(8'hFF);
    settle("t3");
    check("t3_frameErr_lit", 32'(fe_seen), 32'd1);

    // Idle timeout mid-byte
    send_partial(4);
    exp_fe++;
    fe_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frameErr && fe_cyc < 0) fe_cyc = cyc;
    end
    delta = fe_cyc - last_rise;
    tests++;
    if (fe_cyc < 0 || delta < 256 || delta > 262) begin
      fails++;
      $display("FAIL t4_timeout_delay: actual=%0d cycles required=256..262", delta);
    end
    check("t4_aligned", 32'(aligned), 32'd0);
    settle("t4");

    // Overflow with stalled consumer
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    repeat (10) tick();
    check("t5_overflow_lit", 32'(overflow), 32'd1);
    check("t5_byteCnt_lit", 32'(byteCnt), 32'd12);
    check("t5_head_valid", 32'(rx_valid), 32'd1);
    check("t5_head_byte", 32'(rx_byte), 32'h00);
    rx_ready = 1'b1;
    settle("t5");
    check("t5_empty", 32'(rx_valid), 32'd0);

    // Reset mid-byte, then a clean byte
    send_partial(3);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    repeat (4) tick();
    send_byte(8'h5A);
    settle("t6");
    check("t6_byteCnt_lit", 32'(byteCnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
